// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the branch sequencer: branch ops, condition codes,
// PC-source selects and FSM states.
package branch_sequencer_pkg;

  localparam logic [2:0] BCOND_OP_NONE   = 3'b000;
  localparam logic [2:0] BCOND_OP_BRANCH = 3'b001;
  localparam logic [2:0] BCOND_OP_COND   = 3'b010;
  localparam logic [2:0] BCOND_OP_ZERO   = 3'b011;
  localparam logic [2:0] BCOND_OP_NZERO  = 3'b100;
  localparam logic [2:0] BCOND_OP_ALU    = 3'b101;
  localparam logic [2:0] BCOND_OP_LINK   = 3'b110;

  // Pairs differ only in bit 0, which inverts the base test (AL/NV included).
  localparam logic [4:0] BCOND_EQ = 5'd0;
  localparam logic [4:0] BCOND_NE = 5'd1;
  localparam logic [4:0] BCOND_CS = 5'd2;
  localparam logic [4:0] BCOND_CC = 5'd3;
  localparam logic [4:0] BCOND_MI = 5'd4;
  localparam logic [4:0] BCOND_PL = 5'd5;
  localparam logic [4:0] BCOND_VS = 5'd6;
  localparam logic [4:0] BCOND_VC = 5'd7;
  localparam logic [4:0] BCOND_HI = 5'd8;
  localparam logic [4:0] BCOND_LS = 5'd9;
  localparam logic [4:0] BCOND_GE = 5'd10;
  localparam logic [4:0] BCOND_LT = 5'd11;
  localparam logic [4:0] BCOND_GT = 5'd12;
  localparam logic [4:0] BCOND_LE = 5'd13;
  localparam logic [4:0] BCOND_AL = 5'd14;
  localparam logic [4:0] BCOND_NV = 5'd15;

  localparam logic [1:0] PCSEL_PC4    = 2'b00;
  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_REG    = 2'b10;
  localparam logic [1:0] PCSEL_LINK   = 2'b11;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  function automatic logic [1:0] op_pc_sel(input logic [2:0] op);
    case (op)
      BCOND_OP_ALU:  return PCSEL_REG;
      BCOND_OP_LINK: return PCSEL_LINK;
      default:       return PCSEL_TARGET;
    endcase
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// EX-stage branch interface: control decode drives the branch fields, the
// sequencer returns stall/flush/redirect, the PC select, flags and debug state.
interface branch_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  import branch_sequencer_pkg::*;

  // Inputs are level signals sampled every clock; there is no handshake. While
  // stall is high the producer holds br_valid and the branch fields stable.
  logic                 br_valid;
  logic [2:0]           branch_op;
  logic [4:0]           conditional_branch;
  logic                 alu_zero;
  logic                 flags_pending;
  logic                 flag_wr_en;
  logic [3:0]           flag_in;
  logic                 stall;
  logic                 flush;
  logic                 redirect;
  logic [1:0]           pc_sel;
  logic [3:0]           flags;
  logic [CNT_WIDTH-1:0] taken_count;
  state_t               state;

  modport master (
    output br_valid, branch_op, conditional_branch, alu_zero,
           flags_pending, flag_wr_en, flag_in,
    input  stall, flush, redirect, pc_sel, flags, taken_count, state
  );

  modport slave (
    input  br_valid, branch_op, conditional_branch, alu_zero,
           flags_pending, flag_wr_en, flag_in,
    output stall, flush, redirect, pc_sel, flags, taken_count, state
  );

endinterface

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational B.cond evaluator: {N,Z,C,V} plus 5-bit condition -> taken.
// Codes with bit 4 set are not defined and never take.
module branch_sequencer_cond_eval (
  input  logic [3:0] nzcv,
  input  logic [4:0] cond,
  output logic       taken
);

  logic n, z, c, v;
  logic base;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = n ~^ v;
      3'd6:    base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    taken = cond[4] ? 1'b0 : (base ^ cond[0]);
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: owns NZCV, holds B.cond until flags settle,
// selects the PC source and squashes wrong-path instructions after a redirect.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input logic               clk,
  input logic               reset,
  branch_sequencer_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

  state_t                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [3:0]             flags_q, eff_flags;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   cond_taken, br_taken, resolve;
  logic [1:0]             br_sel;
  logic                   stall_c, flush_c, redirect_c;
  logic [1:0]             pc_sel_c;

  // A flag write in the same cycle as the check wins over the stored flags.
  assign eff_flags = bus.flag_wr_en ? bus.flag_in : flags_q;

  branch_sequencer_cond_eval u_cond_eval (
    .nzcv  (eff_flags),
    .cond  (bus.conditional_branch),
    .taken (cond_taken)
  );

  always_comb begin
    br_taken = 1'b0;
    br_sel   = op_pc_sel(bus.branch_op);
    if (bus.br_valid) begin
      case (bus.branch_op)
        BCOND_OP_BRANCH: br_taken = 1'b1;
        BCOND_OP_ZERO:   br_taken = bus.alu_zero;
        BCOND_OP_NZERO:  br_taken = ~bus.alu_zero;
        BCOND_OP_ALU:    br_taken = 1'b1;
        BCOND_OP_LINK:   br_taken = 1'b1;
        BCOND_OP_COND:   br_taken = cond_taken;
        default:         br_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    redirect_c = 1'b0;
    pc_sel_c   = PCSEL_PC4;
    resolve    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid) begin
          if (bus.branch_op == BCOND_OP_COND && bus.flags_pending && !bus.flag_wr_en) begin
            stall_c = 1'b1;
            state_d = ST_WAIT_FLAGS;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      ST_WAIT_FLAGS: begin
        if (bus.flag_wr_en || !bus.flags_pending) begin
          resolve = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Wrong-path branches arriving here are ignored entirely.
        flush_c = 1'b1;
        fcnt_d  = (fcnt_q != '0) ? fcnt_q - 1'b1 : '0;
        if (fcnt_q <= FLUSH_CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (resolve) begin
      state_d = ST_IDLE;
      if (br_taken) begin
        redirect_c = 1'b1;
        flush_c    = 1'b1;
        pc_sel_c   = br_sel;
        if (FLUSH_DEPTH > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      flags_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (bus.flag_wr_en) begin
        flags_q <= bus.flag_in;
      end
      if (resolve && br_taken && count_q != '1) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.redirect    = redirect_c;
  assign bus.pc_sel      = pc_sel_c;
  assign bus.flags       = flags_q;
  assign bus.taken_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus a
// randomized run against a behavioural reference of the branch rules.
`timescale 1ns/1ps
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = 16;
  localparam int S_CW  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [3:0]    m_flags = 4'b0;
  logic [CW-1:0] m_count = '0;

  branch_sequencer_if #(.CNT_WIDTH(CW))   bus ();
  branch_sequencer_if #(.CNT_WIDTH(S_CW)) bus_s ();

  branch_sequencer #(.FLUSH_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-cycle flush and a tiny counter make saturation reachable quickly.
  branch_sequencer #(.FLUSH_DEPTH(1), .CNT_WIDTH(S_CW)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic ref_cond(input logic [3:0] f, input logic [4:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      BCOND_EQ: return z;
      BCOND_NE: return !z;
      BCOND_CS: return cy;
      BCOND_CC: return !cy;
      BCOND_MI: return n;
      BCOND_PL: return !n;
      BCOND_VS: return v;
      BCOND_VC: return !v;
      BCOND_HI: return cy && !z;
      BCOND_LS: return !cy || z;
      BCOND_GE: return n == v;
      BCOND_LT: return n != v;
      BCOND_GT: return !z && (n == v);
      BCOND_LE: return z || (n != v);
      BCOND_AL: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // {taken, sel}
  function automatic logic [2:0] ref_branch(input logic [2:0] op, input logic [4:0] c,
                                            input logic zero, input logic [3:0] f);
    case (op)
      BCOND_OP_BRANCH: return {1'b1, PCSEL_TARGET};
      BCOND_OP_ZERO:   return {zero, PCSEL_TARGET};
      BCOND_OP_NZERO:  return {!zero, PCSEL_TARGET};
      BCOND_OP_ALU:    return {1'b1, PCSEL_REG};
      BCOND_OP_LINK:   return {1'b1, PCSEL_LINK};
      BCOND_OP_COND:   return {ref_cond(f, c), PCSEL_TARGET};
      default:         return 3'b000;
    endcase
  endfunction

  // {stall, flush, redirect, pc_sel}
  function automatic logic [4:0] outs();
    return {bus.stall, bus.flush, bus.redirect, bus.pc_sel};
  endfunction

  function automatic logic [4:0] outs_s();
    return {bus_s.stall, bus_s.flush, bus_s.redirect, bus_s.pc_sel};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.br_valid           = 1'b0;
    bus.branch_op          = BCOND_OP_NONE;
    bus.conditional_branch = 5'd0;
    bus.alu_zero           = 1'b0;
    bus.flags_pending      = 1'b0;
    bus.flag_wr_en         = 1'b0;
    bus.flag_in            = 4'b0;
  endtask

  task automatic idle_s();
    bus_s.br_valid           = 1'b0;
    bus_s.branch_op          = BCOND_OP_NONE;
    bus_s.conditional_branch = 5'd0;
    bus_s.alu_zero           = 1'b0;
    bus_s.flags_pending      = 1'b0;
    bus_s.flag_wr_en         = 1'b0;
    bus_s.flag_in            = 4'b0;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [4:0] c, input logic zero);
    bus.br_valid           = (op != BCOND_OP_NONE);
    bus.branch_op          = op;
    bus.conditional_branch = c;
    bus.alu_zero           = zero;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] f);
    idle();
    bus.flag_wr_en = 1'b1;
    bus.flag_in    = f;
    next_cycle();
    idle();
    m_flags = f;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs(), 5'b0); end
    checks++; if (bus.flags !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
    checks++; if (bus.taken_count !== '0) begin errors++; $display("FAIL reset_count: got %0h expected 0", bus.taken_count); end
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
    next_cycle();
  endtask

  task automatic test_beq();
    write_flags(4'b0100);
    set_br(BCOND_OP_COND, BCOND_EQ, 1'b0);
    @(negedge clk);
    checks++; if (outs() !== {1'b0, 1'b1, 1'b1, PCSEL_TARGET}) begin errors++; $display("FAIL beq_resolve: got %b expected 01101", outs()); end
    next_cycle();
    idle();
    m_count++;
    @(negedge clk);
    checks++; if (outs() !== 5'b01000) begin errors++; $display("FAIL beq_flush: got %b expected 01000", outs()); end
    next_cycle();
    @(negedge clk);
    checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL beq_flush_end: got %b expected 00000", outs()); end
    checks++; if (bus.taken_count !== 16'd1) begin errors++; $display("FAIL beq_count: got %0d expected 1", bus.taken_count); end
    next_cycle();
  endtask

  task automatic test_wait_gt();
    write_flags(4'b0100);
    set_br(BCOND_OP_COND, BCOND_GT, 1'b0);
    bus.flags_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (outs() !== 5'b10000) begin errors++; $display("FAIL gt_stall[%0d]: got %b expected 10000", i, outs()); end
      if (i > 0) begin
        checks++; if (bus.state !== ST_WAIT_FLAGS) begin errors++; $display("FAIL gt_wait_state[%0d]: got %0d expected %0d", i, bus.state, ST_WAIT_FLAGS); end
      end
      next_cycle();
    end
    bus.flag_wr_en = 1'b1;
    bus.flag_in    = 4'b0000;
    @(negedge clk);
    checks++; if (outs() !== 5'b01101) begin errors++; $display("FAIL gt_resolve: got %b expected 01101", outs()); end
    next_cycle();
    idle();
    m_flags = 4'b0000;
    m_count++;
    @(negedge clk);
    checks++; if (outs() !== 5'b01000) begin errors++; $display("FAIL gt_flush: got %b expected 01000", outs()); end
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL gt_flags: got %b expected 0000", bus.flags); end
    next_cycle();
    // Pending drops without a write: resolve on stored flags (Z=0, so NE taken).
    set_br(BCOND_OP_COND, BCOND_NE, 1'b0);
    bus.flags_pending = 1'b1;
    @(negedge clk);
    checks++; if (outs() !== 5'b10000) begin errors++; $display("FAIL ne_stall: got %b expected 10000", outs()); end
    next_cycle();
    bus.flags_pending = 1'b0;
    @(negedge clk);
    checks++; if (outs() !== 5'b01101) begin errors++; $display("FAIL ne_drop_resolve: got %b expected 01101", outs()); end
    next_cycle();
    idle();
    m_count++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.taken_count !== m_count) begin errors++; $display("FAIL wait_count: got %0d expected %0d", bus.taken_count, m_count); end
    next_cycle();
  endtask

  task automatic test_cond_table();
    logic [3:0] tf[4] = '{4'b0110, 4'b0010, 4'b1001, 4'b1000};
    logic [4:0] tc[4] = '{BCOND_LS, BCOND_LS, BCOND_GE, BCOND_GE};
    logic       tt[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      write_flags(tf[i]);
      set_br(BCOND_OP_COND, tc[i], 1'b0);
      @(negedge clk);
      checks++; if (outs() !== (tt[i] ? 5'b01101 : 5'b00000)) begin errors++; $display("FAIL cond_table[%0d]: got %b expected taken=%0d", i, outs(), tt[i]); end
      next_cycle();
      idle();
      if (tt[i]) begin
        m_count++;
        for (int k = 1; k < DEPTH; k++) next_cycle();
      end
      @(negedge clk);
      checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL cond_table_after[%0d]: got %b expected 00000", i, outs()); end
      next_cycle();
    end
  endtask

  task automatic test_pc_sel();
    logic [2:0] top[4] = '{BCOND_OP_NZERO, BCOND_OP_ALU, BCOND_OP_LINK, BCOND_OP_ZERO};
    logic [4:0] texp[4] = '{5'b01101, 5'b01110, 5'b01111, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      set_br(top[i], 5'd0, 1'b0);
      @(negedge clk);
      checks++; if (outs() !== texp[i]) begin errors++; $display("FAIL pc_sel[%0d]: got %b expected %b", i, outs(), texp[i]); end
      next_cycle();
      idle();
      if (texp[i][2]) begin
        m_count++;
        for (int k = 1; k < DEPTH; k++) begin
          @(negedge clk);
          checks++; if (outs() !== 5'b01000) begin errors++; $display("FAIL pc_sel_flush[%0d]: got %b expected 01000", i, outs()); end
          next_cycle();
        end
      end
      @(negedge clk);
      checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL pc_sel_after[%0d]: got %b expected 00000", i, outs()); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (bus.taken_count !== m_count) begin errors++; $display("FAIL pc_sel_count: got %0d expected %0d", bus.taken_count, m_count); end
    next_cycle();
  endtask

  task automatic test_bypass();
    write_flags(4'b0000);
    set_br(BCOND_OP_COND, BCOND_MI, 1'b0);
    bus.flags_pending = 1'b1;
    bus.flag_wr_en    = 1'b1;
    bus.flag_in       = 4'b1000;
    @(negedge clk);
    checks++; if (outs() !== 5'b01101) begin errors++; $display("FAIL bypass_mi: got %b expected 01101", outs()); end
    next_cycle();
    idle();
    m_flags = 4'b1000;
    m_count++;
    @(negedge clk);
    checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL bypass_flags: got %b expected 1000", bus.flags); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_br(BCOND_OP_BRANCH, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (outs() !== 5'b01101) begin errors++; $display("FAIL b2b_first: got %b expected 01101", outs()); end
    next_cycle();
    m_count++;
    set_br(BCOND_OP_COND, BCOND_AL, 1'b0);
    bus.flags_pending = 1'b1;
    @(negedge clk);
    checks++; if (outs() !== 5'b01000) begin errors++; $display("FAIL b2b_ignored: got %b expected 01000", outs()); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL b2b_after: got %b expected 00000", outs()); end
    checks++; if (bus.taken_count !== m_count) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", bus.taken_count, m_count); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [2:0] op, t;
    logic [4:0] c;
    logic       z, wr;
    logic [3:0] fin;
    logic [4:0] exp_o;
    int         gap;
    for (int it = 0; it < 80; it++) begin
      gap = $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) begin
        idle();
        bus.flag_wr_en = 1'($urandom_range(0, 1));
        bus.flag_in    = 4'($urandom);
        @(negedge clk);
        checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL rand_gap_outs it=%0d: got %b expected 00000", it, outs()); end
        checks++; if (bus.flags !== m_flags) begin errors++; $display("FAIL rand_flags it=%0d: got %b expected %b", it, bus.flags, m_flags); end
        checks++; if (bus.taken_count !== m_count) begin errors++; $display("FAIL rand_count it=%0d: got %0d expected %0d", it, bus.taken_count, m_count); end
        if (bus.flag_wr_en) m_flags = bus.flag_in;
        next_cycle();
      end
      op  = 3'($urandom_range(0, 7));
      c   = 5'($urandom_range(0, 17));
      z   = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      fin = 4'($urandom);
      set_br(op, c, z);
      bus.flag_wr_en = wr;
      bus.flag_in    = fin;
      t     = ref_branch(op, c, z, wr ? fin : m_flags);
      exp_o = t[2] ? {1'b0, 1'b1, 1'b1, t[1:0]} : 5'b0;
      @(negedge clk);
      checks++; if (outs() !== exp_o) begin errors++; $display("FAIL rand_resolve it=%0d op=%0d c=%0d: got %b expected %b", it, op, c, outs(), exp_o); end
      if (wr) m_flags = fin;
      if (t[2] && m_count != '1) m_count++;
      next_cycle();
      if (t[2]) begin
        for (int k = 1; k < DEPTH; k++) begin
          set_br(3'($urandom_range(1, 6)), 5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          bus.flags_pending = 1'($urandom_range(0, 1));
          bus.flag_wr_en    = 1'($urandom_range(0, 1));
          bus.flag_in       = 4'($urandom);
          @(negedge clk);
          checks++; if (outs() !== 5'b01000) begin errors++; $display("FAIL rand_flush it=%0d: got %b expected 01000", it, outs()); end
          if (bus.flag_wr_en) m_flags = bus.flag_in;
          next_cycle();
        end
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    int exp_c;
    for (int i = 0; i < 10; i++) begin
      bus_s.br_valid  = 1'b1;
      bus_s.branch_op = BCOND_OP_BRANCH;
      exp_c = (i > 7) ? 7 : i;
      @(negedge clk);
      checks++; if (outs_s() !== 5'b01101) begin errors++; $display("FAIL sat_redirect[%0d]: got %b expected 01101", i, outs_s()); end
      checks++; if (int'(bus_s.taken_count) !== exp_c) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, bus_s.taken_count, exp_c); end
      next_cycle();
    end
    idle_s();
    @(negedge clk);
    checks++; if (outs_s() !== 5'b0) begin errors++; $display("FAIL sat_depth1_end: got %b expected 00000", outs_s()); end
    checks++; if (bus_s.taken_count !== 3'd7 || bus_s.flags !== 4'b0) begin errors++; $display("FAIL sat_final: count %0d flags %b expected 7 and 0000", bus_s.taken_count, bus_s.flags); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_br(BCOND_OP_BRANCH, 5'd0, 1'b0);
    bus.flag_wr_en = 1'b1;
    bus.flag_in    = 4'b1010;
    next_cycle();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_count = '0;
    m_flags = 4'b0;
    @(negedge clk);
    checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL rst_flush_outs: got %b expected 00000", outs()); end
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL rst_flush_state: got %0d expected %0d", bus.state, ST_IDLE); end
    checks++; if (bus.taken_count !== '0) begin errors++; $display("FAIL rst_flush_count: got %0d expected 0", bus.taken_count); end
    checks++; if (bus.flags !== 4'b0) begin errors++; $display("FAIL rst_flush_flags: got %b expected 0000", bus.flags); end
    next_cycle();
    set_br(BCOND_OP_COND, BCOND_AL, 1'b0);
    bus.flags_pending = 1'b1;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    checks++; if (outs() !== 5'b0) begin errors++; $display("FAIL rst_wait_outs: got %b expected 00000", outs()); end
    checks++; if (bus.state !== ST_IDLE || bus.taken_count !== '0) begin errors++; $display("FAIL rst_wait_state: state %0d count %0d expected idle and 0", bus.state, bus.taken_count); end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    idle_s();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_beq();
    test_wait_gt();
    test_cond_table();
    test_pc_sel();
    test_bypass();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Sequences branch resolution for the pipelined LEGv8 core and owns the architectural NZCV flag register.
- Takes the EX-stage branch's `branch_op` / condition code, stalls B.cond while an older flag-setting instruction is still outstanding, then drives the PC-source select.
- On a taken branch it squashes wrong-path younger instructions for a fixed number of cycles.
- Sits between EX-stage control decode and the PC mux / pipeline-register enables.

Parameters:
- FLUSH_DEPTH, 2, number of cycles `flush` stays asserted after a taken branch, redirect cycle included; legal range 1..7.
- CNT_WIDTH, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  EX-stage instruction is a branch (any `branch_op` other than none).
- branch_op  in  3  `BCOND_OP_*` encoding from constants.vh.
- conditional_branch  in  5  `BCOND_*` condition field for B.cond.
- alu_zero  in  1  ALU zero result for CBZ/CBNZ (not a flag).
- flags_pending  in  1  an older flag-setting instruction has not yet written flags.
- flag_wr_en  in  1  flag write strobe this cycle.
- flag_in  in  4  {N,Z,C,V} being written.
- stall  out  1  hold PC, IF/ID and ID/EX this cycle.
- flush  out  1  squash IF/ID and ID/EX contents.
- redirect  out  1  one-cycle pulse: PC loads from `pc_sel` source.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 register (ALU), 11 link/return path.
- flags  out  4  current NZCV register.
- taken_count  out  CNT_WIDTH  saturating count of taken branches.

Behaviour:
- Reset (synchronous, `clk` edge with `reset`=1):
  - state←IDLE, flags←0, flush counter←0, taken_count←0.
  - All outputs 0 from the following cycle; asserting `reset` mid-WAIT or mid-FLUSH aborts to IDLE with no redirect.
- Flag register:
  - Written with `flag_in` on any edge with `flag_wr_en`=1, in every state.
  - Effective flags for a condition check = `flag_in` if `flag_wr_en` else `flags` (same-cycle bypass).
- Taken decode, combinational on inputs:
  - BRANCH: always taken, sel 01.
  - ZERO: taken iff `alu_zero`, sel 01.
  - NZERO: taken iff !`alu_zero`, sel 01.
  - ALU: always taken, sel 10.
  - 3'b110: always taken, sel 11.
  - COND: condition over effective flags, sel 01.
    - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
    - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
    - AL 1; NV 0.
  - Any other op: not taken.
- FSM states IDLE, WAIT_FLAGS, FLUSH.
- IDLE:
  - `br_valid`=0: outputs 0, `pc_sel`=00.
  - `br_valid`=1, op COND, `flags_pending`=1, `flag_wr_en`=0: `stall`=1, next WAIT_FLAGS, no redirect.
  - Otherwise resolve same cycle (zero latency):
    - taken → `redirect`=1, `pc_sel`=sel, `flush`=1, taken_count++ (saturate at all-ones). Next FLUSH with counter=FLUSH_DEPTH-1, or IDLE if FLUSH_DEPTH=1.
    - not taken → `pc_sel`=00, stay IDLE.
- WAIT_FLAGS:
  - `stall`=1 while `flag_wr_en`=0. Inputs `br_valid` and the branch fields are held stable by the stall.
  - Cycle with `flag_wr_en`=1: `stall`=0, resolve exactly as in IDLE using the bypassed `flag_in`.
  - `flags_pending` dropping without `flag_wr_en` resolves using `flags`.
- FLUSH:
  - `flush`=1, `redirect`=0, `pc_sel`=00, `stall`=0. Counter decrements each cycle; exit to IDLE when it reaches 0.
  - `br_valid` is ignored in FLUSH (wrong-path instruction): no stall, no count.
- `stall` and `redirect` are never asserted in the same cycle.

Decomposition:
- constants.vh: add `BCOND_OP_LINK` (3'b110) and `PCSEL_*` codes (00/01/10/11) alongside the existing `BCOND_*` / `BCOND_OP_*`.
- FSM state encodings are local parameters.
- One natural sub-module: `cond_eval`, a combinational {N,Z,C,V} + 5-bit condition → taken evaluator, reused by the non-pipelined core.

Test Plan:
- Reset mid-FLUSH: branch taken, then `reset` asserted the next cycle → following cycle `flush`=0, state IDLE, `taken_count`=0, `flags`=0.
- B.EQ, flags=4'b0100, not pending → same cycle `redirect`=1, `pc_sel`=01, `flush`=1 for exactly 2 cycles, `taken_count`=1.
- B.GT, `flags_pending`=1 for 3 cycles, then `flag_wr_en`=1 with `flag_in`=4'b0000 → `stall`=1 for 3 cycles, redirect on the 4th cycle with `stall`=0; `flags`=0000 afterwards.
- B.LS with stored flags C=1,Z=1 → taken; with C=1,Z=0 → not taken, `pc_sel`=00, no flush.
- CBNZ `alu_zero`=0 → `pc_sel`=01; BR (op ALU) → `pc_sel`=10; op 3'b110 → `pc_sel`=11; each followed by FLUSH_DEPTH flush cycles.
- Same-cycle `flag_wr_en`=1, `flag_in`=4'b1000 with B.MI in IDLE → taken via bypass. Back-to-back `br_valid` during FLUSH → ignored. Force `taken_count`=16'hFFFF, one more taken → stays 16'hFFFF.
